// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed latency,
// accepts mthi/mtlo when idle and raises the D-stage stall request.
module mdu_e #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic [31:0] WData,
    input  logic        D_MDUse,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        StallReq
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   pend_hi_q, pend_hi_d;
    logic [W-1:0]   pend_lo_q, pend_lo_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    // Datapath: sign/zero-extended 64-bit product and magnitude-based divide
    logic [2*W-1:0] mul_a, mul_b, prod;
    logic           is_unsigned, a_neg, b_neg, div_zero;
    logic [W-1:0]   a_mag, b_mag, b_safe, quo_mag, rem_mag, quo, rem;
    logic           done_c;

    always_comb begin
        is_unsigned = Op[0];
        mul_a       = is_unsigned ? {{W{1'b0}}, A} : {{W{A[W-1]}}, A};
        mul_b       = is_unsigned ? {{W{1'b0}}, B} : {{W{B[W-1]}}, B};
        prod        = mul_a * mul_b;

        a_neg    = ~is_unsigned & A[W-1];
        b_neg    = ~is_unsigned & B[W-1];
        a_mag    = a_neg ? (W'(0) - A) : A;
        b_mag    = b_neg ? (W'(0) - B) : B;
        div_zero = (B == W'(0));
        b_safe   = div_zero ? W'(1) : b_mag;
        quo_mag  = a_mag / b_safe;
        rem_mag  = a_mag % b_safe;
        // Quotient truncates toward zero; remainder follows the dividend's sign
        quo      = (a_neg ^ b_neg) ? (W'(0) - quo_mag) : quo_mag;
        rem      = a_neg ? (W'(0) - rem_mag) : rem_mag;
    end

    assign done_c = (state_q == BUSY) && (cnt_q == CW'(1));

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = BUSY;
                    cnt_d   = Op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    if (!Op[1]) begin
                        pend_hi_d = prod[2*W-1:W];
                        pend_lo_d = prod[W-1:0];
                    end else if (div_zero) begin
                        // Divide by zero completes with HI/LO unchanged
                        pend_hi_d = hi_q;
                        pend_lo_d = lo_q;
                    end else begin
                        pend_hi_d = rem;
                        pend_lo_d = quo;
                    end
                end else begin
                    if (HIWrite) hi_d = WData;
                    if (LOWrite) lo_d = WData;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (done_c) begin
                    state_d = IDLE;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        Busy     = (state_q == BUSY);
        HI       = hi_q;
        LO       = lo_q;
        StallReq = D_MDUse & (Start | (state_q == BUSY));
    end

endmodule

// File: tb/tb_mdu_e.sv
// Scoreboard bench for mdu_e: stimulus pushes expected HI/LO/latency, a negedge
// monitor pops and checks on every completion.
module tb_mdu_e;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        Clk = 1'b0;
    logic        Reset, Start, HIWrite, LOWrite, D_MDUse;
    logic [1:0]  Op;
    logic [31:0] A, B, WData;
    logic        Busy, StallReq;
    logic [31:0] HI, LO;

    mdu_e #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .WData(WData), .D_MDUse(D_MDUse),
        .Busy(Busy), .HI(HI), .LO(LO), .StallReq(StallReq)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic on wide integers; returns {HI, LO}
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb_, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (op)
            2'b00: p = 64'(sa * sb_);
            2'b01: p = {32'h0, a} * {32'h0, b};
            2'b10: begin
                q = sa / sb_;
                r = sa % sb_;
                p = {r[31:0], q[31:0]};
            end
            default: begin
                uq = a / b;
                ur = a % b;
                p  = {ur, uq};
            end
        endcase
        return p;
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic also_write);
        logic [63:0] r;
        exp_t        e;
        if (op[1] && b == 32'h0) r = {m_hi, m_lo};
        else                     r = ref_op(op, a, b);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.n  = op[1] ? DIV_N : MULT_N;
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        Op = op; A = a; B = b; Start = 1'b1;
        HIWrite = also_write; LOWrite = also_write; WData = $urandom;
        #1;
        chk("stall_on_start", 32'(StallReq), 32'(D_MDUse));
        tick;
        Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
    endtask

    task automatic wait_idle;
        int k = 0;
        while (Busy && k < 100) begin
            tick;
            k++;
        end
        chk("idle_timeout", 32'(Busy), 32'd0);
    endtask

    task automatic mt_write(input logic sel_hi, input logic [31:0] d);
        if (sel_hi) HIWrite = 1'b1; else LOWrite = 1'b1;
        WData = d;
        tick;
        HIWrite = 1'b0; LOWrite = 1'b0;
        if (sel_hi) begin m_hi = d; chk("mthi", HI, d); end
        else        begin m_lo = d; chk("mtlo", LO, d); end
        chk("mt_no_busy", 32'(Busy), 32'd0);
    endtask

    // Completion monitor
    logic busy_prev = 1'b0;
    logic rst_prev  = 1'b0;
    int   busy_len  = 0;
    always @(negedge Clk) begin
        exp_t e;
        if (Busy) busy_len++;
        if (busy_prev && !Busy) begin
            if (!rst_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got HI=%h LO=%h expected no result", HI, LO);
                end else begin
                    e = sb.pop_front();
                    chk("result_hi", HI, e.hi);
                    chk("result_lo", LO, e.lo);
                    chk("busy_cycles", 32'(busy_len), 32'(e.n));
                end
            end
            busy_len = 0;
        end
        if (Reset) busy_len = 0;
        busy_prev = Busy;
        rst_prev  = Reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        Reset = 1'b1; Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; D_MDUse = 1'b0;
        Op = 2'b00; A = '0; B = '0; WData = '0;
        tick; tick;
        Reset = 1'b0;
        D_MDUse = 1'b1;
        #1;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_hi", HI, 32'h0);
        chk("reset_lo", LO, 32'h0);
        chk("reset_stall", 32'(StallReq), 32'd0);
        D_MDUse = 1'b0;
        tick;

        issue(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
        wait_idle;
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFF1);

        issue(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0);
        wait_idle;
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_idle;
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle;
        chk("div_ovf_lo", LO, 32'h80000000);
        chk("div_ovf_hi", HI, 32'h0);

        // Divide by zero, with a write and a Start injected while busy
        mt_write(1'b1, 32'h12345678);
        mt_write(1'b0, 32'h9ABCDEF0);
        issue(2'b11, 32'd7, 32'd0, 1'b0);
        tick;
        HIWrite = 1'b1; WData = 32'hDEADBEEF;
        tick;
        HIWrite = 1'b0;
        chk("busy_mthi_ignored", HI, 32'h12345678);
        Start = 1'b1; Op = 2'b00; A = 32'd3; B = 32'd3;
        tick;
        Start = 1'b0;
        wait_idle;
        chk("div0_hi", HI, 32'h12345678);
        chk("div0_lo", LO, 32'h9ABCDEF0);

        // Stall request across a mult with and without a D-stage user
        D_MDUse = 1'b1;
        issue(2'b00, $urandom, $urandom, 1'b0);
        for (int i = 0; i < MULT_N; i++) begin
            chk("stall_busy", 32'(StallReq), 32'd1);
            tick;
        end
        chk("stall_after", 32'(StallReq), 32'd0);
        chk("busy_after", 32'(Busy), 32'd0);
        D_MDUse = 1'b0;
        issue(2'b01, $urandom, $urandom, 1'b0);
        for (int i = 0; i < MULT_N; i++) begin
            chk("no_stall", 32'(StallReq), 32'd0);
            tick;
        end
        wait_idle;

        // Start together with mthi/mtlo: the write must be dropped
        issue(2'b01, 32'd6, 32'd7, 1'b1);
        wait_idle;

        // Reset in the third busy cycle of a divide
        issue(2'b10, 32'd100, 32'd7, 1'b0);
        tick; tick;
        Reset = 1'b1;
        sb.delete();
        m_hi = 32'h0; m_lo = 32'h0;
        tick;
        Reset = 1'b0;
        chk("rst_mid_busy", 32'(Busy), 32'd0);
        chk("rst_mid_hi", HI, 32'h0);
        chk("rst_mid_lo", LO, 32'h0);
        issue(2'b10, 32'hFFFFFF9C, 32'd7, 1'b0);
        wait_idle;

        // Randomized back-to-back traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                mt_write(1'($urandom_range(0, 1)), $urandom);
            end else begin
                op = 2'($urandom_range(0, 3));
                a  = $urandom;
                case ($urandom_range(0, 7))
                    0:       b = 32'h0;
                    1:       b = 32'($urandom_range(1, 16));
                    2:       b = 32'hFFFFFFFF;
                    default: b = $urandom;
                endcase
                if ($urandom_range(0, 9) == 0) a = 32'h80000000;
                issue(op, a, b, 1'b0);
                wait_idle;
            end
        end

        tick; tick;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_e.md
# mdu_e

Multiply/divide unit in the E stage of the five-stage pipeline, holding the architectural HI/LO registers. It accepts mult/multu/div/divu, runs them for a fixed multi-cycle latency, and handles mthi/mtlo writes. It produces the stall request that the hazard logic turns into a deasserted FD-register enable and a DE-register flush. This keeps any later HI/LO-dependent instruction in D until the unit is idle.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (1..31)
- DIV_CYCLES, 10, Busy duration for div/divu (1..31)

Ports:
- Clk  input  1  pipeline clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; clears all state
- Start  input  1  E-stage instruction is mult/multu/div/divu, one-cycle qualifier
- Op  input  2  00 mult, 01 multu, 10 div, 11 divu
- A  input  32  rs operand (forwarded E-stage value)
- B  input  32  rt operand (forwarded E-stage value)
- HIWrite  input  1  E-stage mthi
- LOWrite  input  1  E-stage mtlo
- WData  input  32  mthi/mtlo data (forwarded rs)
- D_MDUse  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- Busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- StallReq  output  1  D_MDUse & (Start | Busy), combinational

## Operation
- Two states, IDLE and BUSY; 5-bit down-counter Cnt; 32-bit pending registers PendHI and PendLO.
- IDLE, Start=1:
  - Compute the result from A/B/Op into PendHI/PendLO.
  - Load Cnt with MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY:
  - Decrement Cnt each cycle.
  - When Cnt==1: copy PendHI/PendLO into HI/LO, clear Busy, go to IDLE.
- Arithmetic:
  - mult: signed 64-bit product; HI = [63:32], LO = [31:0].
  - multu: unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
- Divide by zero (div or divu, B==0): the unit still goes Busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
- mthi/mtlo in IDLE: HI or LO = WData at the next edge; Busy is not asserted.
- Start while BUSY: ignored. The pipeline never issues this because StallReq holds the instruction in D.
- HIWrite/LOWrite while BUSY: ignored.
- Start together with HIWrite/LOWrite in IDLE: Start wins; the write is dropped.
- Reset (wins over everything, including mid-operation): HI=0, LO=0, Busy=0, Cnt=0, PendHI=PendLO=0, state IDLE. Any pending result is discarded.

## Timing
- Reset values: Busy=0, HI=0x00000000, LO=0x00000000. StallReq follows its equation and is 0 unless D_MDUse and Start are both high.
- Start sampled at edge t0 →
  - Busy=1 during cycles t0+1 .. t0+N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO take the new values at edge t0+N, the same edge at which Busy falls.
- A new Start is accepted in the first cycle after Busy falls (back-to-back issue, zero gap).
- mthi/mtlo: one-cycle latency; HI/LO are visible in the cycle after the edge.
- mfhi/mflo in E read HI/LO combinationally. This is correct by construction because StallReq keeps mfhi/mflo out of E while Start or Busy is high.
- StallReq is purely combinational from D_MDUse, Start and Busy, with no register delay, so the FD enable is held low in the same cycle.

## Test plan
- Signed multiply: Op=00, A=0xFFFFFFFD (-3), B=5, Start for 1 cycle → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Unsigned multiply: Op=01, A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide: Op=10, A=0xFFFFFFF9 (-7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then Op=10, A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: first mthi 0x12345678 and mtlo 0x9ABCDEF0 (each visible next cycle). Then divu 7/0 → Busy for 10 cycles; HI/LO remain 0x12345678/0x9ABCDEF0. An mthi or a second Start issued during Busy → no effect.
- Stall: D_MDUse=1 throughout a mult → StallReq=1 on the Start cycle and all 5 Busy cycles, 0 in the cycle after Busy falls. D_MDUse=0 → StallReq=0 throughout.
- Reset mid-operation: assert Reset at the 3rd Busy cycle of a div → next cycle Busy=0, HI=LO=0. A following Start completes normally with a full 10-cycle latency.
